// File: rtl/fpga_cfg_loader_if.sv
// Configuration stream and fabric-side signals of the FPGA configuration loader.
// The master drives the start request and the beat stream; the slave (loader) drives everything else.
interface fpga_cfg_loader_if #(
   parameter int WORD_W    = 224,
   parameter int NUM_WORDS = 43,
   parameter int CHUNK_W   = 32
);
   logic                 start;
   logic                 cfg_valid;
   logic [CHUNK_W-1:0]   cfg_data;
   logic                 cfg_ready;
   logic [WORD_W-1:0]    configs_in;
   logic [NUM_WORDS-1:0] configs_en;
   logic                 ff_en;
   logic                 rdy;
   logic                 busy;
   logic [5:0]           word_idx;

   modport master (
      output start, cfg_valid, cfg_data,
      input  cfg_ready, configs_in, configs_en, ff_en, rdy, busy, word_idx
   );

   modport slave (
      input  start, cfg_valid, cfg_data,
      output cfg_ready, configs_in, configs_en, ff_en, rdy, busy, word_idx
   );
endinterface

// File: rtl/fpga_cfg_loader.sv
// Assembles CHUNK_W-wide beats into WORD_W configuration words, strobes them into the
// fabric one word at a time, then sequences flip-flop enable and ready with settle delays.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, all outputs low, waiting for start
// S_LOAD   | accepting beats of the current word (cfg_ready high)
// S_WRITE  | one-cycle strobe of configs_en[word_idx]
// S_SETTLE | all words written, waiting SETTLE cycles before ff_en
// S_ENABLE | ff_en high, waiting SETTLE cycles before rdy
// S_DONE   | fabric running (ff_en, rdy high); start triggers reconfiguration
module fpga_cfg_loader #(
   parameter int WORD_W    = 224,
   parameter int NUM_WORDS = 43,
   parameter int CHUNK_W   = 32,
   parameter int SETTLE    = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   fpga_cfg_loader_if.slave  bus
);
   localparam int BEATS = WORD_W / CHUNK_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

   localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
   localparam logic [5:0]           LAST_WORD = 6'(NUM_WORDS - 1);
   localparam logic [CW-1:0]        CNT_INIT  = CW'(SETTLE - 1);
   localparam logic [NUM_WORDS-1:0] EN_ONE    = NUM_WORDS'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_WRITE  = 3'd2,
      S_SETTLE = 3'd3,
      S_ENABLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic [5:0]          word_q, word_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WORD_W-1:0]   cfg_q, cfg_d;

   logic                 cfg_ready;
   logic [NUM_WORDS-1:0] configs_en;
   logic                 ff_en;
   logic                 rdy;
   logic                 busy;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      cfg_d      = cfg_q;
      cfg_ready  = 1'b0;
      configs_en = '0;
      ff_en      = 1'b0;
      rdy        = 1'b0;
      busy       = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (bus.start) begin
               state_d = S_LOAD;
               beat_d  = '0;
               word_d  = '0;
            end
         end

         S_LOAD: begin
            cfg_ready = 1'b1;
            if (bus.cfg_valid) begin
               cfg_d[int'(beat_q) * CHUNK_W +: CHUNK_W] = bus.cfg_data;
               if (beat_q == LAST_BEAT) begin
                  state_d = S_WRITE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end

         S_WRITE: begin
            configs_en = EN_ONE << word_q;
            if (word_q == LAST_WORD) begin
               state_d = S_SETTLE;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = S_LOAD;
               word_d  = word_q + 1'b1;
               beat_d  = '0;
            end
         end

         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_ENABLE;
               cnt_d   = CNT_INIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_ENABLE: begin
            ff_en = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_DONE: begin
            busy  = 1'b0;
            ff_en = 1'b1;
            rdy   = 1'b1;
            // Reconfiguration: previously loaded bits stay on configs_in until overwritten.
            if (bus.start) begin
               state_d = S_LOAD;
               beat_d  = '0;
               word_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.cfg_ready  = cfg_ready;
   assign bus.configs_in = cfg_q;
   assign bus.configs_en = configs_en;
   assign bus.ff_en      = ff_en;
   assign bus.rdy        = rdy;
   assign bus.busy       = busy;
   assign bus.word_idx   = word_q;
endmodule
